// File: rtl/ii_mem_arbiter.sv
// ii_mem_arbiter: shares the single-port integral-image RAM between the VGA
// display reader (fixed priority, never stalled), the Haar detector (reads)
// and the integral-image builder (writes). The detector and builder share the
// cycles the display leaves free, round-robin, over ready/valid handshakes.
// Every read grant is tagged so returned data reaches only its own client.
//
// Optional build macro II_ARB_STATS_EN adds stats_clr / det_stall_cnt, a
// saturating count of cycles the detector waited with a pending request.
module ii_mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 20,
  parameter int RD_LAT = 1
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              det_valid,
  input  logic [ADDR_W-1:0] det_addr,
  output logic              det_ready,
  output logic [DATA_W-1:0] det_rdata,
  output logic              det_rvalid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              disp_conflict
`ifdef II_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       det_stall_cnt
`endif
);

  localparam int TAG_W = 2 * RD_LAT;

  // Read tags: which client a returning word belongs to.
  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_DISP = 2'b01;
  localparam logic [1:0] TAG_DET  = 2'b10;

  logic              gnt_disp;
  logic              gnt_det;
  logic              gnt_wr;

  logic              rr_last_q, rr_last_d;   // 0 = builder won last, 1 = detector
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [TAG_W-1:0]  tag_in_ext;
  logic [1:0]        tag_in;
  logic [1:0]        tag_out;

  logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
  logic              disp_rvalid_q, disp_rvalid_d;
  logic [DATA_W-1:0] det_rdata_q, det_rdata_d;
  logic              det_rvalid_q, det_rvalid_d;
  logic              conflict_q, conflict_d;

  // Grant selection: display first, then round-robin between detector and
  // builder. Nothing is granted while reset is asserted.
  always_comb begin
    gnt_disp = 1'b0;
    gnt_det  = 1'b0;
    gnt_wr   = 1'b0;
    if (rst_n) begin
      if (disp_req) begin
        gnt_disp = 1'b1;
      end else if (det_valid && wr_valid) begin
        if (rr_last_q) gnt_wr  = 1'b1;
        else           gnt_det = 1'b1;
      end else if (det_valid) begin
        gnt_det = 1'b1;
      end else if (wr_valid) begin
        gnt_wr = 1'b1;
      end
    end
  end

  // Memory port and handshake outputs follow the grant combinationally.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    det_ready = gnt_det;
    wr_ready  = gnt_wr;
    if (gnt_disp) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (gnt_det) begin
      mem_en   = 1'b1;
      mem_addr = det_addr;
    end else if (gnt_wr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end
  end

  // Next-state: round-robin pointer, tag shift pipeline, return routing and
  // the sticky display/write conflict flag.
  always_comb begin
    rr_last_d = rr_last_q;
    if (gnt_wr)  rr_last_d = 1'b0;
    if (gnt_det) rr_last_d = 1'b1;

    tag_in = TAG_NONE;
    if (gnt_disp)     tag_in = TAG_DISP;
    else if (gnt_det) tag_in = TAG_DET;

    tag_in_ext      = '0;
    tag_in_ext[1:0] = tag_in;
    // Oldest tag sits in the top slot and aligns with mem_rdata.
    tag_d   = (tag_q << 2) | tag_in_ext;
    tag_out = tag_q[TAG_W-1 -: 2];

    disp_rdata_d  = disp_rdata_q;
    disp_rvalid_d = 1'b0;
    det_rdata_d   = det_rdata_q;
    det_rvalid_d  = 1'b0;
    if (tag_out == TAG_DISP) begin
      disp_rdata_d  = mem_rdata;
      disp_rvalid_d = 1'b1;
    end else if (tag_out == TAG_DET) begin
      det_rdata_d  = mem_rdata;
      det_rvalid_d = 1'b1;
    end

    // A write that collides with a display read is deferred, so the display
    // sees the old word; record that it happened.
    conflict_d = conflict_q;
    if (disp_req && wr_valid && (disp_addr == wr_addr)) conflict_d = 1'b1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      rr_last_q     <= 1'b1;
      tag_q         <= '0;
      disp_rdata_q  <= '0;
      disp_rvalid_q <= 1'b0;
      det_rdata_q   <= '0;
      det_rvalid_q  <= 1'b0;
      conflict_q    <= 1'b0;
    end else begin
      rr_last_q     <= rr_last_d;
      tag_q         <= tag_d;
      disp_rdata_q  <= disp_rdata_d;
      disp_rvalid_q <= disp_rvalid_d;
      det_rdata_q   <= det_rdata_d;
      det_rvalid_q  <= det_rvalid_d;
      conflict_q    <= conflict_d;
    end
  end

  assign disp_rdata    = disp_rdata_q;
  assign disp_rvalid   = disp_rvalid_q;
  assign det_rdata     = det_rdata_q;
  assign det_rvalid    = det_rvalid_q;
  assign disp_conflict = conflict_q;

`ifdef II_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stats_clr_q, stats_clr_d;

  // Stall counter: clears on a rising stats_clr, otherwise saturates upward.
  always_comb begin
    stats_clr_d = stats_clr;
    stall_cnt_d = stall_cnt_q;
    if (stats_clr && !stats_clr_q) begin
      stall_cnt_d = '0;
    end else if (det_valid && !det_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      stats_clr_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stats_clr_q <= stats_clr_d;
    end
  end

  assign det_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ii_mem_arbiter.sv
// Directed bench for ii_mem_arbiter with a 1-cycle-latency memory model whose
// unwritten words read back as addr+5.
module tb_ii_mem_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 20;

  logic              clk_vga = 1'b0;
  logic              rst_n;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              det_valid;
  logic [ADDR_W-1:0] det_addr;
  logic              det_ready;
  logic [DATA_W-1:0] det_rdata;
  logic              det_rvalid;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              disp_conflict;
`ifdef II_ARB_STATS_EN
  logic              stats_clr;
  logic [15:0]       det_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  bit [DATA_W-1:0] mem_arr [32768];
  bit              written [32768];

  always #5 clk_vga = ~clk_vga;

  ii_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut (
    .clk_vga(clk_vga), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .det_valid(det_valid), .det_addr(det_addr), .det_ready(det_ready),
    .det_rdata(det_rdata), .det_rvalid(det_rvalid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .disp_conflict(disp_conflict)
`ifdef II_ARB_STATS_EN
    , .stats_clr(stats_clr), .det_stall_cnt(det_stall_cnt)
`endif
  );

  // Memory model, read latency 1.
  always @(posedge clk_vga) begin
    if (mem_en && mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_we)
      mem_rdata <= written[mem_addr] ? mem_arr[mem_addr]
                                     : (DATA_W'({5'b0, mem_addr}) + 20'd5);
  end

  task automatic next_cycle();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req = 1'b0; disp_addr = '0;
    det_valid = 1'b0; det_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef II_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    disp_req = 1'b1; det_valid = 1'b1; wr_valid = 1'b1;
    det_addr = 15'h5; wr_addr = 15'h6; wr_data = 20'h7;
    next_cycle();
    next_cycle();
    @(negedge clk_vga);
    checks++; if (det_ready !== 1'b0) begin errors++; $display("FAIL rst_det_ready: got %b want 0", det_ready); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL rst_disp_rvalid: got %b want 0", disp_rvalid); end
    checks++; if (det_rvalid !== 1'b0) begin errors++; $display("FAIL rst_det_rvalid: got %b want 0", det_rvalid); end
    checks++; if (disp_rdata !== 20'h0) begin errors++; $display("FAIL rst_disp_rdata: got %h want 0", disp_rdata); end
    checks++; if (det_rdata !== 20'h0) begin errors++; $display("FAIL rst_det_rdata: got %h want 0", det_rdata); end
    checks++; if (disp_conflict !== 1'b0) begin errors++; $display("FAIL rst_conflict: got %b want 0", disp_conflict); end
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
  endtask

  // Display streams 160 addresses while detector and builder wait.
  task automatic test_display_line();
    logic exp_v;
    do_reset();
    for (int c = 0; c < 163; c++) begin
      disp_req  = (c < 160);
      disp_addr = 15'(c);
      det_valid = (c < 160); det_addr = 15'h0400;
      wr_valid  = (c < 160); wr_addr = 15'h7000; wr_data = 20'h11111;
      @(negedge clk_vga);
      exp_v = (c >= 2) && (c <= 161);
      checks++; if (det_ready !== 1'b0) begin errors++; $display("FAIL disp_det_ready c=%0d: got %b want 0", c, det_ready); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL disp_wr_ready c=%0d: got %b want 0", c, wr_ready); end
      checks++; if (disp_rvalid !== exp_v) begin errors++; $display("FAIL disp_rvalid c=%0d: got %b want %b", c, disp_rvalid, exp_v); end
      if (exp_v) begin
        checks++; if (disp_rdata !== 20'(c + 3)) begin errors++; $display("FAIL disp_rdata c=%0d: got %h want %h", c, disp_rdata, 20'(c + 3)); end
      end
      checks++; if (det_rvalid !== 1'b0) begin errors++; $display("FAIL disp_det_rvalid c=%0d: got %b want 0", c, det_rvalid); end
      next_cycle();
    end
    idle_inputs();
  endtask

  // Detector and builder both pending: W,D,W,D,W,D from reset.
  task automatic test_round_robin();
    int wn = 0;
    int dn = 0;
    int pulses = 0;
    logic exp_w, exp_d, exp_rv;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      det_valid = (c < 6); det_addr = 15'(16'h0200 + dn);
      wr_valid  = (c < 6); wr_addr = 15'(16'h3000 + wn); wr_data = 20'(20'h50000 + wn);
      @(negedge clk_vga);
      exp_w  = (c < 6) && (c % 2 == 0);
      exp_d  = (c < 6) && (c % 2 == 1);
      exp_rv = (c == 3) || (c == 5) || (c == 7);
      checks++; if (wr_ready !== exp_w) begin errors++; $display("FAIL rr_wr_ready c=%0d: got %b want %b", c, wr_ready, exp_w); end
      checks++; if (det_ready !== exp_d) begin errors++; $display("FAIL rr_det_ready c=%0d: got %b want %b", c, det_ready, exp_d); end
      checks++; if (mem_we !== exp_w) begin errors++; $display("FAIL rr_mem_we c=%0d: got %b want %b", c, mem_we, exp_w); end
      checks++; if (det_rvalid !== exp_rv) begin errors++; $display("FAIL rr_det_rvalid c=%0d: got %b want %b", c, det_rvalid, exp_rv); end
      if (exp_rv) begin
        checks++; if (det_rdata !== 20'(20'h0205 + (c - 3) / 2)) begin errors++; $display("FAIL rr_det_rdata c=%0d: got %h want %h", c, det_rdata, 20'(20'h0205 + (c - 3) / 2)); end
      end
      if (det_rvalid === 1'b1) pulses++;
      if (exp_w) wn++;
      if (exp_d) dn++;
      next_cycle();
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL rr_pulses: got %0d want 3", pulses); end
    idle_inputs();
  endtask

  // Detector waits 4 cycles behind the display, then reads 0x1234.
  task automatic test_det_stall();
    logic exp_dv;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      disp_req  = (c < 4); disp_addr = 15'(16'h0010 + c);
      det_valid = (c <= 4); det_addr = 15'h1234;
      @(negedge clk_vga);
      exp_dv = (c >= 2) && (c <= 5);
      checks++; if (det_ready !== (c == 4)) begin errors++; $display("FAIL stall_det_ready c=%0d: got %b want %b", c, det_ready, (c == 4)); end
      checks++; if (det_rvalid !== (c == 6)) begin errors++; $display("FAIL stall_det_rvalid c=%0d: got %b want %b", c, det_rvalid, (c == 6)); end
      if (c == 6) begin
        checks++; if (det_rdata !== 20'h01239) begin errors++; $display("FAIL stall_det_rdata: got %h want 01239", det_rdata); end
      end
      checks++; if (disp_rvalid !== exp_dv) begin errors++; $display("FAIL stall_disp_rvalid c=%0d: got %b want %b", c, disp_rvalid, exp_dv); end
      if (exp_dv) begin
        checks++; if (disp_rdata !== 20'(20'h13 + c)) begin errors++; $display("FAIL stall_disp_rdata c=%0d: got %h want %h", c, disp_rdata, 20'(20'h13 + c)); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  // Display read and write to the same address in the same cycle.
  task automatic test_conflict();
    do_reset();
    disp_req = 1'b1; disp_addr = 15'h0100;
    wr_valid = 1'b1; wr_addr = 15'h0100; wr_data = 20'hABCDE;
    @(negedge clk_vga);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL cf_wr_ready0: got %b want 0", wr_ready); end
    checks++; if (disp_conflict !== 1'b0) begin errors++; $display("FAIL cf_flag0: got %b want 0", disp_conflict); end
    next_cycle();
    disp_req = 1'b0;
    @(negedge clk_vga);
    checks++; if (disp_conflict !== 1'b1) begin errors++; $display("FAIL cf_flag1: got %b want 1", disp_conflict); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL cf_wr_ready1: got %b want 1", wr_ready); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL cf_mem_we: got %b want 1", mem_we); end
    checks++; if (mem_addr !== 15'h0100) begin errors++; $display("FAIL cf_mem_addr: got %h want 0100", mem_addr); end
    checks++; if (mem_wdata !== 20'hABCDE) begin errors++; $display("FAIL cf_mem_wdata: got %h want abcde", mem_wdata); end
    next_cycle();
    wr_valid = 1'b0; disp_req = 1'b1; disp_addr = 15'h0100;
    @(negedge clk_vga);
    checks++; if (disp_rvalid !== 1'b1) begin errors++; $display("FAIL cf_stale_rvalid: got %b want 1", disp_rvalid); end
    checks++; if (disp_rdata !== 20'h00105) begin errors++; $display("FAIL cf_stale_rdata: got %h want 00105", disp_rdata); end
    checks++; if (disp_conflict !== 1'b1) begin errors++; $display("FAIL cf_flag2: got %b want 1", disp_conflict); end
    next_cycle();
    disp_req = 1'b0;
    next_cycle();
    @(negedge clk_vga);
    checks++; if (disp_rvalid !== 1'b1) begin errors++; $display("FAIL cf_new_rvalid: got %b want 1", disp_rvalid); end
    checks++; if (disp_rdata !== 20'hABCDE) begin errors++; $display("FAIL cf_new_rdata: got %h want abcde", disp_rdata); end
    checks++; if (disp_conflict !== 1'b1) begin errors++; $display("FAIL cf_flag4: got %b want 1", disp_conflict); end
    next_cycle();
    idle_inputs();
  endtask

  // Reset pulse while a detector read is in flight.
  task automatic test_reset_mid();
    det_valid = 1'b1; det_addr = 15'h0050;
    @(negedge clk_vga);
    checks++; if (det_ready !== 1'b1) begin errors++; $display("FAIL mid_det_ready: got %b want 1", det_ready); end
    checks++; if (disp_conflict !== 1'b1) begin errors++; $display("FAIL mid_flag_sticky: got %b want 1", disp_conflict); end
    next_cycle();
    rst_n = 1'b0; disp_req = 1'b1; wr_valid = 1'b1; wr_addr = 15'h0060; det_addr = 15'h0051;
    @(negedge clk_vga);
    checks++; if (det_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_det_ready: got %b want 0", det_ready); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_wr_ready: got %b want 0", wr_ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL mid_rst_mem_en: got %b want 0", mem_en); end
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_vga);
      checks++; if (det_rvalid !== 1'b0) begin errors++; $display("FAIL mid_det_rvalid c=%0d: got %b want 0", c, det_rvalid); end
      checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL mid_disp_rvalid c=%0d: got %b want 0", c, disp_rvalid); end
      checks++; if (disp_rdata !== 20'h0) begin errors++; $display("FAIL mid_disp_rdata c=%0d: got %h want 0", c, disp_rdata); end
      checks++; if (det_rdata !== 20'h0) begin errors++; $display("FAIL mid_det_rdata c=%0d: got %h want 0", c, det_rdata); end
      checks++; if (disp_conflict !== 1'b0) begin errors++; $display("FAIL mid_conflict c=%0d: got %b want 0", c, disp_conflict); end
      next_cycle();
    end
    det_valid = 1'b1; wr_valid = 1'b1; det_addr = 15'h0052; wr_addr = 15'h0061;
    @(negedge clk_vga);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL mid_tie_wr: got %b want 1", wr_ready); end
    checks++; if (det_ready !== 1'b0) begin errors++; $display("FAIL mid_tie_det: got %b want 0", det_ready); end
    next_cycle();
    idle_inputs();
  endtask

`ifdef II_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      disp_req = 1'b1; disp_addr = 15'(c); det_valid = 1'b1; det_addr = 15'h0700;
      next_cycle();
    end
    idle_inputs();
    @(negedge clk_vga);
    checks++; if (det_stall_cnt !== 16'd10) begin errors++; $display("FAIL stats_cnt: got %0d want 10", det_stall_cnt); end
    next_cycle();
    stats_clr = 1'b1;
    next_cycle();
    @(negedge clk_vga);
    checks++; if (det_stall_cnt !== 16'd0) begin errors++; $display("FAIL stats_clr: got %0d want 0", det_stall_cnt); end
    next_cycle();
    idle_inputs();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    test_reset();
    test_display_line();
    test_round_robin();
    test_det_stall();
    test_conflict();
    test_reset_mid();
`ifdef II_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ii_mem_arbiter.md
# ii_mem_arbiter

Shares the single-port integral-image block RAM (160x120 entries, 20-bit words) between three requesters: the VGA display reader, the Haar window evaluator of the face detector, and the integral-image builder that writes each new frame. The display reader is real-time and is never stalled. The builder and the detector share the remaining cycles round-robin through a ready/valid handshake. The block sits between those three clients and the memory's single address/data port, and it tags each read so that every client receives only its own returned data.

## Interface
- `ADDR_W`, 15, memory address width (19200 words)
- `DATA_W`, 20, memory word width
- `RD_LAT`, 1, memory read latency in cycles, from address to `mem_rdata` valid; legal range 1..3
- `clk_vga`  in  1  single clock for the block; all logic is on its rising edge
- `rst_n`  in  1  reset: synchronous, active-low
- `disp_req`  in  1  display read request; honoured in the same cycle, with no ready signal
- `disp_addr`  in  ADDR_W  display read address
- `disp_rdata`  out  DATA_W  display read data
- `disp_rvalid`  out  1  display read data valid
- `det_valid`  in  1  detector read request
- `det_addr`  in  ADDR_W  detector read address
- `det_ready`  out  1  detector request accepted this cycle
- `det_rdata`  out  DATA_W  detector read data
- `det_rvalid`  out  1  detector read data valid
- `wr_valid`  in  1  builder write request
- `wr_addr`  in  ADDR_W  builder write address
- `wr_data`  in  DATA_W  builder write data
- `wr_ready`  out  1  builder write accepted this cycle
- `mem_en`  out  1  memory port enable
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid `RD_LAT` cycles after `mem_en` with `!mem_we`
- `disp_conflict`  out  1  sticky error flag; set if a display read was ever requested at the same time as a write to the same address

## Operation
- The memory port is combinational from the requests. Exactly one client is granted per cycle.
- Priority 1: `disp_req`=1 grants the display.
  - `mem_en`=1, `mem_we`=0, `mem_addr`=`disp_addr`.
  - `det_ready`=0 and `wr_ready`=0.
- Priority 2: if there is no display request, the detector and the builder share the port round-robin.
  - A 1-bit `rr_last` register records the last winner (0 = builder, 1 = detector).
  - If both are valid, the client that did not win last is granted.
  - If only one is valid, that client is granted.
  - `rr_last` updates only on a detector or builder grant.
- Builder grant: `mem_we`=1, `mem_addr`=`wr_addr`, `mem_wdata`=`wr_data`, `wr_ready`=1.
- Detector grant: `mem_we`=0, `mem_addr`=`det_addr`, `det_ready`=1.
- If no client is granted: `mem_en`=0, `mem_we`=0, and address/data are don't-care (driven to 0).
- Read tagging:
  - Each read grant pushes a 2-bit tag into a shift pipeline `RD_LAT` deep: 01 = display, 10 = detector, 00 = no read or write.
  - When the tag leaves the pipeline, `mem_rdata` is captured into that client's output register, and that client's `rvalid` pulses for 1 cycle.
- Conflict flag: `disp_conflict` is set when `disp_req`=1 and `wr_valid`=1 with `disp_addr`==`wr_addr` (the write is deferred, so the display reads stale data). It clears only on reset.
- Reset mid-operation:
  - The tag pipeline is flushed to 00, so in-flight reads produce no `rvalid`.
  - `rr_last` is set to 1, so the builder wins the first tie.
  - Requesters must re-issue any request that was pending.

## Timing
- Reset values: `disp_rdata`=0, `disp_rvalid`=0, `det_rdata`=0, `det_rvalid`=0, `disp_conflict`=0.
  - While `rst_n`=0: `det_ready`=0, `wr_ready`=0, `mem_en`=0, `mem_we`=0.
- Read latency, request to `rvalid`: `RD_LAT`+1 cycles for both the display and the detector. The display latency is fixed and independent of load.
- A handshake completes on `valid`&&`ready` in the same cycle.
  - `det_addr` and `wr_addr`/`wr_data` must stay stable while `valid`=1 and `ready`=0.
  - `valid` must not drop before `ready`.
- Throughput: one access per cycle. During a 160-wide active line the display holds the port continuously; the detector and builder progress only in blanking.
- Back-to-back detector reads give back-to-back `det_rvalid`, in order.

## Configuration
- `II_ARB_STATS_EN`
  - Defined: adds output `det_stall_cnt` (16 bits), which counts cycles with `det_valid`=1 and `det_ready`=0. It saturates at 16'hFFFF, clears on reset, and clears on the rising edge of a new input `stats_clr`.
  - Undefined: neither port exists and no counter logic is built.

## Test plan
- Reset, then `disp_req`=1 with `disp_addr`=0..159 on consecutive cycles, using a memory model that returns data = addr+5 -> `disp_rvalid` high for 160 consecutive cycles, starting 2 cycles (`RD_LAT`=1) after the first request, with data 5..164 in order; `det_ready` and `wr_ready` stay 0 throughout.
- `det_valid` and `wr_valid` both held at 1 with no display requests, for 6 cycles after reset -> grants alternate W,D,W,D,W,D (builder first); the detector receives 3 `det_rvalid` pulses.
- `det_valid`=1 at addr 0x1234 while `disp_req` is held for 4 cycles -> `det_ready`=0 for 4 cycles, then 1; `det_rdata` = mem[0x1234] after 2 more cycles.
- `disp_req` with `disp_addr`=0x0100 and `wr_valid` with `wr_addr`=0x0100 in the same cycle -> `disp_conflict`=1 from the next cycle; the write completes the following cycle; the flag stays 1 until `rst_n`=0.
- Detector read issued, then `rst_n` pulsed low for 1 cycle before the data returns -> no `det_rvalid`; all outputs are at their reset values.
- With `II_ARB_STATS_EN` defined: `det_valid` held for 10 cycles under continuous `disp_req` -> `det_stall_cnt`=10.
